// File: rtl/rtype_seq_ctrl.sv
// rtype_seq_ctrl: multi-cycle sequencer for the R-type fragment datapath.
// Validates an accepted instruction, steers reg-file/ALU fields, writes back and returns {rd, result}.
module rtype_seq_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic [4:0]       rf_rd_addr1,
    output logic [4:0]       rf_rd_addr2,
    output logic [4:0]       rf_wr_addr,
    output logic             rf_wr_en,
    output logic [XLEN-1:0]  rf_wr_data,
    output logic [2:0]       alu_funct3,
    output logic [6:0]       alu_funct7,
    input  logic [XLEN-1:0]  alu_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_val,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);
    // state  | meaning
    // IDLE   | waiting for an instruction, in_ready high
    // ILL    | rejected encoding, illegal pulses for this cycle
    // READ   | operands addressed; ALU result captured on exit
    // WB     | reg-file write of captured result (suppressed for rd == x0)
    // RESP   | result offered until out_ready; may accept the next instruction
    typedef enum logic [2:0] {S_IDLE, S_ILL, S_READ, S_WB, S_RESP} state_t;

    localparam logic [6:0]       OP_RTYPE = 7'b0110011;
    localparam logic [6:0]       F7_ALT   = 7'b0100000;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic [31:7]      inst_q;      // opcode bits are never needed after the legality check
    logic [XLEN-1:0]  result_q;
    logic [CNT_W-1:0] cnt_q;
    logic             legal;
    logic             accept;
    logic             retire;

    always_comb begin
        legal = 1'b0;
        if (in_inst[6:0] == OP_RTYPE) begin
            if (in_inst[31:25] == 7'd0)
                legal = 1'b1;
            else if (in_inst[31:25] == F7_ALT &&
                     (in_inst[14:12] == 3'b000 || in_inst[14:12] == 3'b101))
                legal = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        rf_wr_en  = 1'b0;
        out_valid = 1'b0;
        illegal   = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = legal ? S_READ : S_ILL;
            end
            S_ILL: begin
                illegal   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_READ: state_nxt = S_WB;
            S_WB: begin
                rf_wr_en  = (inst_q[11:7] != 5'd0);
                state_nxt = S_RESP;
            end
            S_RESP: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready)
                    state_nxt = in_valid ? (legal ? S_READ : S_ILL) : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign retire = (state == S_RESP) & out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            inst_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                inst_q <= in_inst[31:7];
            if (state == S_READ)
                result_q <= alu_result;
            if (retire && cnt_q != CNT_MAX)
                cnt_q <= cnt_q + CNT_ONE;
        end
    end

    assign rf_rd_addr1 = inst_q[19:15];
    assign rf_rd_addr2 = inst_q[24:20];
    assign rf_wr_addr  = inst_q[11:7];
    assign alu_funct3  = inst_q[14:12];
    assign alu_funct7  = inst_q[31:25];
    assign rf_wr_data  = result_q;
    assign out_rd      = inst_q[11:7];
    assign out_val     = result_q;
    assign retired_cnt = cnt_q;

endmodule
